// File: rtl/i2s_ser.sv
// i2s_ser: I2S transmitter, 64-bit stereo frames in, BCK/LRCK/DATA out.
// A one-frame holding register feeds a shift register loaded at slot 1.
module i2s_ser #(
  parameter int BCK_DIV = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        enable,
  input  logic [1:0]  data_bits,
  input  logic [63:0] data,
  input  logic        valid,
  output logic        ready,
  output logic        bck,
  output logic        lrck,
  output logic        sdata,
  output logic        busy,
  output logic        underrun
);

  localparam int DW = (BCK_DIV > 2) ? $clog2(BCK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(BCK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(BCK_DIV / 2);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [DW-1:0] r_div;
  logic [5:0]    r_slot;
  logic [5:0]    w_slot_nxt;
  logic [63:0]   r_hold;
  logic [63:0]   r_shift;
  logic [63:0]   w_mask;
  logic [63:0]   w_load;
  logic          r_ready;
  logic          r_bck;
  logic          r_lrck;
  logic          r_sdata;
  logic          r_busy;
  logic          r_underrun;
  logic          w_tick;
  logic          w_stop;
  logic          w_start;
  logic          w_load_en;

  assign w_tick     = (r_state == RUN) && (r_div == '0);
  assign w_stop     = w_tick && (r_slot == 6'd63) && !enable;
  assign w_start    = (r_state == IDLE) && enable && !r_ready;
  assign w_load_en  = w_tick && (r_slot == 6'd0);
  assign w_slot_nxt = r_slot + 6'd1;

  always_comb begin
    w_mask = '1;
    case (data_bits)
      2'd0:    w_mask = 64'hFFFF_0000_FFFF_0000;
      2'd1:    w_mask = 64'hFFFF_FF00_FFFF_FF00;
      default: w_mask = '1;
    endcase
  end

  // an empty holding register at load time sends a silent frame
  assign w_load = r_ready ? '0 : (r_hold & w_mask);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_start) w_state_nxt = RUN;
      RUN:     if (w_stop)  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_div      <= '0;
      r_slot     <= 6'd63;
      r_hold     <= '0;
      r_shift    <= '0;
      r_ready    <= 1'b1;
      r_bck      <= 1'b0;
      r_lrck     <= 1'b1;
      r_sdata    <= 1'b0;
      r_busy     <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= 1'b0;
      r_busy     <= (w_state_nxt == RUN);
      if (valid && r_ready) begin
        r_hold  <= data;
        r_ready <= 1'b0;
      end
      if (r_state == IDLE) begin
        r_div   <= '0;
        r_slot  <= 6'd63;
        r_bck   <= 1'b0;
        r_lrck  <= 1'b1;
        r_sdata <= 1'b0;
      end else begin
        r_div <= (r_div == DIV_LAST) ? '0 : r_div + DW'(1);
        if (r_div == DIV_HALF) r_bck <= 1'b1;
        if (w_tick) begin
          r_bck <= 1'b0;
          if (w_stop) begin
            r_lrck  <= 1'b1;
            r_sdata <= 1'b0;
            r_shift <= '0;
          end else begin
            r_slot <= w_slot_nxt;
            r_lrck <= w_slot_nxt[5];
            if (w_load_en) begin
              r_sdata    <= w_load[63];
              r_shift    <= {w_load[62:0], 1'b0};
              r_underrun <= r_ready;
              if (!r_ready) begin
                r_hold  <= '0;
                r_ready <= 1'b1;
              end
            end else begin
              r_sdata <= r_shift[63];
              r_shift <= {r_shift[62:0], 1'b0};
            end
          end
        end
      end
    end
  end

  assign ready    = r_ready;
  assign bck      = r_bck;
  assign lrck     = r_lrck;
  assign sdata    = r_sdata;
  assign busy     = r_busy;
  assign underrun = r_underrun;

endmodule

// File: tb/tb_i2s_ser.sv
// tb_i2s_ser: randomized and directed checks of i2s_ser against a
// slot-arithmetic model of the I2S stream.
module tb_i2s_ser;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  data_bits = 2'd2;
  logic [63:0] data = '0;
  logic        valid = 1'b0;
  logic        ready, bck, lrck, sdata, busy, underrun;

  i2s_ser #(.BCK_DIV(D)) dut (
    .clk(clk), .resetn(resetn), .enable(enable),
    .data_bits(data_bits), .data(data), .valid(valid),
    .ready(ready), .bck(bck), .lrck(lrck), .sdata(sdata),
    .busy(busy), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int nprint = 0;

  bit          m_run = 1'b0;
  bit          m_full = 1'b0;
  int          m_j = 0;
  logic [63:0] m_hold = '0;
  logic [63:0] m_cur = '0;
  logic e_bck = 0, e_lrck = 1, e_sdata = 0;
  logic e_ready = 1, e_busy = 0, e_und = 0;

  function automatic logic [63:0] fmask(logic [1:0] b);
    case (b)
      2'd0:    return 64'hFFFF_0000_FFFF_0000;
      2'd1:    return 64'hFFFF_FF00_FFFF_FF00;
      default: return '1;
    endcase
  endfunction

  // m_j = clks since the first tick of the stream; slot = (m_j/D)%64
  always @(posedge clk) begin : model
    bit acc;
    int s;
    if (!resetn) begin
      m_run = 0; m_full = 0; m_j = 0; m_hold = '0; m_cur = '0;
      e_bck = 0; e_lrck = 1; e_sdata = 0;
      e_ready = 1; e_busy = 0; e_und = 0;
    end else begin
      acc = valid && !m_full;
      e_und = 0;
      if (!m_run) begin
        if (enable && m_full) begin
          m_run = 1;
          m_j = -1;
        end
      end else begin
        m_j++;
        if (m_j % D == 0) begin
          s = (m_j / D) % 64;
          if (s == 0 && !enable) begin
            m_run = 0;
            m_cur = '0;
          end else if (s == 1) begin
            if (m_full) begin
              m_cur = m_hold & fmask(data_bits);
              m_full = 0;
            end else begin
              m_cur = '0;
              e_und = 1;
            end
          end
        end
      end
      if (acc) begin
        m_hold = data;
        m_full = 1;
      end
      if (m_run && m_j >= 0) begin
        s = (m_j / D) % 64;
        e_bck = (m_j % D) >= D / 2;
        e_lrck = (s >= 32);
        e_sdata = (s == 0) ? m_cur[0] : m_cur[64 - s];
      end else begin
        e_bck = 0; e_lrck = 1; e_sdata = 0;
      end
      e_ready = !m_full;
      e_busy = m_run;
    end
  end

  int   cyc = 0;
  int   und_cnt = 0;
  int   low_cnt = 0;
  bit   q_bits[$];
  int   hs_t[$];
  logic p_bck = 1'b0;

  always @(posedge clk) begin : compare
    #1;
    cyc++;
    total++;
    if ({bck, lrck, sdata, ready, busy, underrun} !==
        {e_bck, e_lrck, e_sdata, e_ready, e_busy, e_und}) begin
      bad++;
      if (nprint < 40) begin
        nprint++;
        $display("FAIL cycle %0d: bck/lrck/sdata/ready/busy/underrun got %b expected %b",
                 cyc, {bck, lrck, sdata, ready, busy, underrun},
                 {e_bck, e_lrck, e_sdata, e_ready, e_busy, e_und});
      end
    end
    if (bck && !p_bck) q_bits.push_back(sdata);
    if (underrun) und_cnt++;
    if (busy && !lrck) low_cnt++;
    p_bck = bck;
  end

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic bit cond(int kind, int arg);
    case (kind)
      0:       return ready;
      1:       return !busy;
      2:       return q_bits.size() >= arg;
      default: return und_cnt >= arg;
    endcase
  endfunction

  task automatic wait_for(string nm, int kind, int arg, int max);
    int n = 0;
    while (!cond(kind, arg) && n < max) begin
      @(negedge clk);
      n++;
    end
    if (!cond(kind, arg)) begin
      total++;
      bad++;
      $display("FAIL %s: got false expected true within %0d clks", nm, max);
    end
  endtask

  task automatic send(logic [63:0] d);
    @(negedge clk);
    wait_for("send_ready", 0, 0, 2000);
    if (ready) begin
      valid = 1'b1;
      data = d;
      @(negedge clk);
      hs_t.push_back(cyc);
      valid = 1'b0;
    end
  endtask

  // bits of frame f as received on bck rises; unsent bits read as 0
  function automatic logic [63:0] frame_bits(int f);
    logic [63:0] v = '0;
    for (int i = 1; i <= 64; i++)
      if (f * 64 + i < q_bits.size()) v[64 - i] = q_bits[f * 64 + i];
    return v;
  endfunction

  task automatic clr();
    q_bits.delete();
    hs_t.delete();
    und_cnt = 0;
    low_cnt = 0;
  endtask

  logic [63:0] pat [8];
  int r0;

  initial begin
    // reset with valid held high
    valid = 1'b1;
    data = 64'h1234_5678_9ABC_DEF0;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_out", 64'({bck, lrck, sdata, ready, busy, underrun}),
        64'b010100);
    valid = 1'b0;
    resetn = 1'b1;
    enable = 1'b1;
    repeat (5) @(negedge clk);
    chk("no_capture_busy", 64'(busy), 64'd0);
    chk("no_capture_ready", 64'(ready), 64'd1);

    // single 32-bit frame then an underrun frame
    clr();
    data_bits = 2'd2;
    send(64'hA5A5_0001_8000_00FF);
    wait_for("t2_xfer", 0, 0, 600);
    wait_for("t2_und", 3, 1, 800);
    enable = 1'b0;
    wait_for("t2_idle", 1, 0, 800);
    chk("t2_frame", frame_bits(0), 64'hA5A5_0001_8000_00FF);
    chk("t2_rises", 64'(q_bits.size()), 64'd128);
    chk("t2_und", 64'(und_cnt), 64'd1);
    chk("t2_lrck_low", 64'(low_cnt), 64'd256);

    // 16-bit masking
    clr();
    enable = 1'b1;
    data_bits = 2'd0;
    send('1);
    wait_for("t3_xfer", 0, 0, 600);
    data_bits = 2'd2;
    enable = 1'b0;
    wait_for("t3_idle", 1, 0, 800);
    chk("t3_frame", frame_bits(0), 64'hFFFF_0000_FFFF_0000);
    chk("t3_rises", 64'(q_bits.size()), 64'd64);

    // eight back-to-back frames
    clr();
    for (int k = 0; k < 8; k++)
      pat[k] = (64'h1111_1111_1111_1111 * 64'(k + 1)) ^ 64'(k + 1);
    enable = 1'b1;
    for (int k = 0; k < 8; k++) send(pat[k]);
    wait_for("t4_xfer", 0, 0, 600);
    enable = 1'b0;
    wait_for("t4_idle", 1, 0, 800);
    chk("t4_hs", 64'(hs_t.size()), 64'd8);
    chk("t4_und", 64'(und_cnt), 64'd0);
    for (int k = 2; k < hs_t.size(); k++)
      chk($sformatf("t4_hs_gap%0d", k), 64'(hs_t[k] - hs_t[k - 1]), 64'd256);
    for (int k = 0; k < 7; k++)
      chk($sformatf("t4_frame%0d", k), frame_bits(k), pat[k]);

    // stop requested at slot 40
    clr();
    enable = 1'b1;
    send(64'hDEAD_BEEF_0BAD_F00D);
    wait_for("t5_xfer", 0, 0, 600);
    wait_for("t5_slot40", 2, 40, 400);
    enable = 1'b0;
    wait_for("t5_idle", 1, 0, 400);
    chk("t5_rises", 64'(q_bits.size()), 64'd64);
    r0 = q_bits.size();
    repeat (100) @(negedge clk);
    chk("t5_no_bck", 64'(q_bits.size()), 64'(r0));
    chk("t5_lrck", 64'(lrck), 64'd1);
    chk("t5_und", 64'(und_cnt), 64'd0);

    // one frame withheld
    clr();
    enable = 1'b1;
    send(64'h0F0F_1234_F0F0_5679);
    wait_for("t5b_xfer", 0, 0, 600);
    repeat (300) @(negedge clk);
    send(64'h8765_4321_CAFE_BABE);
    wait_for("t5b_xfer2", 0, 0, 600);
    enable = 1'b0;
    wait_for("t5b_idle", 1, 0, 800);
    chk("t5b_und", 64'(und_cnt), 64'd1);
    chk("t5b_frame0", frame_bits(0), 64'h0F0F_1234_F0F0_5679);
    chk("t5b_frame1", frame_bits(1), 64'd0);
    chk("t5b_frame2", frame_bits(2), 64'h8765_4321_CAFE_BABE & ~64'd1);

    // reset at slot 20
    clr();
    enable = 1'b1;
    send(64'hFFFF_FFFF_FFFF_FFFF);
    wait_for("t6_xfer", 0, 0, 600);
    wait_for("t6_slot20", 2, 20, 400);
    resetn = 1'b0;
    @(negedge clk);
    chk("t6_reset", 64'({bck, lrck, sdata, ready, busy, underrun}),
        64'b010100);
    resetn = 1'b1;
    clr();
    send(64'h0123_4567_89AB_CDEF);
    wait_for("t6_xfer2", 0, 0, 600);
    send(64'hFEDC_BA98_7654_3210);
    wait_for("t6_xfer3", 0, 0, 600);
    enable = 1'b0;
    wait_for("t6_idle", 1, 0, 800);
    chk("t6_frame0", frame_bits(0), 64'h0123_4567_89AB_CDEF);
    chk("t6_frame1", frame_bits(1), 64'hFEDC_BA98_7654_3210);

    // random traffic checked by the model each clk
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      enable = ($urandom % 16) != 0;
      valid = ($urandom % 3) == 0;
      data = {$urandom, $urandom};
      if ($urandom % 8 == 0) data_bits = 2'($urandom);
      resetn = ($urandom % 1500) != 0;
    end
    @(negedge clk);
    resetn = 1'b1;
    valid = 1'b0;
    enable = 1'b0;
    wait_for("rand_idle", 1, 0, 800);
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
